vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA 640x480@60 raster timing: pixel coordinates x/y, hsync/vsync and an active-video flag.
//  Sits directly upstream of videoGen, which consumes x/y and returns r/g/b.
//  Also drives the display/DAC sync pins.
//  Runs from the system clk; an internal divider produces the pixel-rate tick.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (>=1); 2 gives 25 MHz pixels from a 50 MHz clk
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL = 525)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  x            out  10  current pixel column, 0..H_TOTAL-1
//  y            out  10  current line, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
//  active       out  1   1 when x<H_ACTIVE and y<V_ACTIVE
//  pix_tick     out  1   1-clk pulse when x/y/syncs update
//  frame_start  out  1   1-clk pulse when outputs present (0,0)
//  frame_count  out  16  frames started (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate): x=0, y=0, hsync=1, vsync=1, active=0, pix_tick=0, frame_start=0, frame_count=0.
//    Internal counters h_cnt=0, v_cnt=0, div_cnt=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. A tick occurs on the clk edge where div_cnt==CLK_DIV-1.
//    CLK_DIV=1 gives a tick on every clk.
//  - On each tick, all outputs are registered together from the current (h_cnt,v_cnt), then the counters advance:
//    - x<=h_cnt, y<=v_cnt
//    - active<=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
//    - hsync<=~(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1])  -> low for x=656..751
//    - vsync<=~(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1])  -> low for y=490..491
//  - Outputs are therefore mutually consistent, and the counters run one tick ahead of them.
//  - Between ticks all outputs hold. pix_tick=1 only on the clk after a tick edge.
//  - Counter wrap: h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt increments.
//    If also v_cnt==V_TOTAL-1 -> v_cnt=0. Counters never exceed their totals.
//  - frame_start=1 for exactly the one clk in which pix_tick=1 and the new outputs are x=0, y=0. Otherwise 0.
//  - First tick after reset release presents x=0, y=0, active=1, frame_start=1.
//  - Reset asserted mid-frame: every output returns to its reset value immediately.
//    Release restarts at (0,0) with a full CLK_DIV cycles before the first tick.
//  - All width arithmetic is 10-bit unsigned. Parameters must satisfy H_TOTAL, V_TOTAL <= 1024.
// CONFIGURATION
//  VGA_FRAME_COUNTER_EN defined:
//    - frame_count increments by 1 on every frame_start; 16-bit, wraps 0xFFFF->0x0000.
//    - First frame after reset gives frame_count=1.
//  VGA_FRAME_COUNTER_EN undefined:
//    - frame_count tied to 16'h0000 and no counter register is built. Port list unchanged.
// TESTING
//  1. CLK_DIV=2, release rst -> first pix_tick on 2nd clk edge with x=0, y=0, active=1, frame_start=1, hsync=1, vsync=1.
//  2. Sweep one line -> active falls at x=640. hsync=0 exactly for x=656..751 (96 ticks). x wraps 799->0 with y+1.
//  3. Sweep one frame -> vsync=0 only for y=490..491 (1600 ticks). active=0 for y>=480.
//     y wraps 524->0 with frame_start. Period 420000 ticks = 840000 clk.
//  4. Assert rst at x=300, y=100 -> same instant: x=0, y=0, hsync=1, vsync=1, active=0. Release -> test 1 repeats.
//  5. CLK_DIV=1 -> pix_tick high every clk, x increments every clk, hsync low for 96 consecutive clk.
//  6. VGA_FRAME_COUNTER_EN defined, run 3 frames -> frame_count=3 after the 3rd frame_start.
//     Undefined -> frame_count stays 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and registered x/y/sync/active outputs.
// Optional frame counter is built only when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pix_tick,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             tick;
  logic             at_origin;

  assign tick      = (div_cnt == DIV_LAST);
  assign at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Outputs are sampled from the counters on the tick, so the counters lead by one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      frame_start <= tick && at_origin;
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        x      <= h_cnt;
        y      <= v_cnt;
        active <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync  <= ~((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        vsync  <= ~((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fcnt <= '0;
    else if (tick && at_origin)
      fcnt <= fcnt + 16'd1;
  end

  assign frame_count = fcnt;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance for line timing, plus a tiny
// CLK_DIV=1 raster (16x8 total) so several whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---- full-size instance, CLK_DIV=2
  logic        rst0;
  logic [9:0]  x0, y0;
  logic        hs0, vs0, act0, pt0, fs0;
  logic [15:0] fc0;

  vga_timing_gen u0 (
    .clk(clk), .rst(rst0), .x(x0), .y(y0), .hsync(hs0), .vsync(vs0),
    .active(act0), .pix_tick(pt0), .frame_start(fs0), .frame_count(fc0)
  );

  // ---- tiny raster: H_TOTAL=16 (hsync low x=10..12), V_TOTAL=8 (vsync low y=5..6)
  logic        rst1;
  logic [9:0]  x1, y1;
  logic        hs1, vs1, act1, pt1, fs1;
  logic [15:0] fc1;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u1 (
    .clk(clk), .rst(rst1), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
    .active(act1), .pix_tick(pt1), .frame_start(fs1), .frame_count(fc1)
  );

  typedef struct {
    int e;
    int x;
    int y;
    bit hs;
    bit vs;
    bit act;
    bit pt;
    bit fs;
  } vec_t;

  function automatic logic [31:0] pack0();
    return {5'd0, x0, y0, hs0, vs0, act0, pt0, fs0};
  endfunction

  function automatic logic [31:0] packv(input vec_t v);
    return {5'd0, 10'(v.x), 10'(v.y), v.hs, v.vs, v.act, v.pt, v.fs};
  endfunction

  logic [31:0] rst_word;
  assign rst_word = {5'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  localparam int FC3 =
`ifdef VGA_FRAME_COUNTER_EN
    3;
`else
    0;
`endif

  initial begin
    vec_t tv[13];
    int   cyc;
    int   hlow, actn, wraps, px, py, found;
    int   errs, fsn, ptn, run, maxrun, fc_at3;

    // Edge e counts rising edges after release; with CLK_DIV=2 edge 2k presents pixel k-1.
    tv[0]  = '{1,    0,   0, 1, 1, 0, 0, 0};
    tv[1]  = '{2,    0,   0, 1, 1, 1, 1, 1};
    tv[2]  = '{3,    0,   0, 1, 1, 1, 0, 0};
    tv[3]  = '{4,    1,   0, 1, 1, 1, 1, 0};
    tv[4]  = '{1280, 639, 0, 1, 1, 1, 1, 0};
    tv[5]  = '{1282, 640, 0, 1, 1, 0, 1, 0};
    tv[6]  = '{1312, 655, 0, 1, 1, 0, 1, 0};
    tv[7]  = '{1314, 656, 0, 0, 1, 0, 1, 0};
    tv[8]  = '{1504, 751, 0, 0, 1, 0, 1, 0};
    tv[9]  = '{1506, 752, 0, 1, 1, 0, 1, 0};
    tv[10] = '{1600, 799, 0, 1, 1, 0, 1, 0};
    tv[11] = '{1601, 799, 0, 1, 1, 0, 0, 0};
    tv[12] = '{1602, 0,   1, 1, 1, 1, 1, 0};

    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_u0", pack0(), rst_word);
    chk("reset_fc0", {16'd0, fc0}, 32'd0);

    @(negedge clk);
    rst0 = 1'b0;
    cyc  = 0;
    foreach (tv[i]) begin
      while (cyc < tv[i].e) begin
        @(posedge clk);
        cyc++;
      end
      #1;
      chk($sformatf("vec%0d_e%0d", i, tv[i].e), pack0(), packv(tv[i]));
    end

    // One full line of ticks: x=1..799 of line 1 then x=0 of line 2.
    hlow  = 0;
    actn  = 0;
    wraps = 0;
    px    = int'(x0);
    py    = int'(y0);
    repeat (1600) begin
      @(posedge clk);
      #1;
      if (pt0) begin
        if (!hs0) hlow++;
        if (act0) actn++;
        if (px == 799 && x0 == 10'd0 && int'(y0) == py + 1) wraps++;
        px = int'(x0);
        py = int'(y0);
      end
    end
    chk("line_hsync_low", hlow, 96);
    chk("line_active", actn, 640);
    chk("line_wrap", wraps, 1);

    // Async reset in mid-line, then the startup sequence must repeat.
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (x0 == 10'd300) found = 1;
    end
    chk("find_x300", found, 1);
    #2;
    rst0 = 1'b1;
    #1;
    chk("async_reset_u0", pack0(), rst_word);
    @(negedge clk);
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    chk("rerelease_e1", pack0(), packv(tv[0]));
    @(posedge clk);
    #1;
    chk("rerelease_e2", pack0(), packv(tv[1]));

    // Tiny raster, CLK_DIV=1: three frames of 128 clk each, checked against a counter model.
    @(negedge clk);
    rst1   = 1'b0;
    errs   = 0;
    fsn    = 0;
    ptn    = 0;
    run    = 0;
    maxrun = 0;
    fc_at3 = -1;
    for (int e = 1; e <= 384; e++) begin
      int n, ex, ey;
      bit ehs, evs, eact, efs;
      @(posedge clk);
      #1;
      n    = e - 1;
      ex   = n % 16;
      ey   = (n / 16) % 8;
      ehs  = !(ex >= 10 && ex <= 12);
      evs  = !(ey >= 5 && ey <= 6);
      eact = (ex < 8) && (ey < 4);
      efs  = (ex == 0) && (ey == 0);
      if (int'(x1) != ex || int'(y1) != ey || hs1 != ehs || vs1 != evs ||
          act1 != eact || fs1 != efs)
        errs++;
      if (pt1) ptn++;
      if (fs1) fsn++;
      if (!hs1) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (e == 257) fc_at3 = int'(fc1);
    end
    chk("tiny_model_errs", errs, 0);
    chk("tiny_pix_tick_every_clk", ptn, 384);
    chk("tiny_frame_starts", fsn, 3);
    chk("tiny_hsync_run", maxrun, 3);
    chk("tiny_fc_after_3rd", fc_at3, FC3);
    chk("tiny_fc_end", {16'd0, fc1}, FC3);

    #2;
    rst1 = 1'b1;
    #1;
    chk("async_reset_u1", {5'd0, x1, y1, hs1, vs1, act1, pt1, fs1}, rst_word);
    chk("reset_fc1", {16'd0, fc1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
